// File: rtl/seq_alu.sv
// seq_alu -- multi-cycle arithmetic unit (add, sub, mul, div, mod).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; aborts any running operation
//   start    operation request, taken only while busy=0
//   command  opcode: 0 ground, 1 add, 2 sub, 3 mul, 4 div, 5 mod, 6-15 ground
//   in_a     operand A (WIDTH bits), captured on accept
//   in_b     operand B (WIDTH bits), captured on accept
//   busy     high while the multiply or divide sequencer is iterating
//   done     one-cycle pulse; result/error are fresh in this cycle
//   result   2*WIDTH-bit result of the last completed operation (held)
//   error    error flag of the last completed operation (held with result)
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// unit is in IDLE or DONE (busy=0). start seen while busy=1 is dropped, not
// queued. Every accepted request yields exactly one done pulse unless reset
// intervenes. Holding start high in a DONE cycle chains the next request, so
// single-cycle operations can complete on every clock.
//
// Optional feature: define SEQ_ALU_DIV_EN to build the restoring divider
// (commands 4/5). Without it, commands 4/5 finish in one cycle with
// result=0 and error=1.
//
// The FSM state is held in the signal 'state' for checkers to probe.

module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         command,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               error
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
`ifdef SEQ_ALU_DIV_EN
        , ST_DIV = 2'd3
`endif
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;

    // Shift-add multiplier: the multiplicand moves left and the multiplier
    // moves right each step, so iteration i adds A<<i when B[i]=1.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mul_acc_next;

    // Add/sub is evaluated from the live inputs and only used on the accept
    // edge, so the result register is the only state it touches.
    logic [WIDTH-1:0]   as_b;
    logic [WIDTH:0]     as_sum;
    logic               as_ovf;

`ifdef SEQ_ALU_DIV_EN
    // Restoring divider: quo starts as the dividend and is shifted out MSB
    // first into the partial remainder while quotient bits shift in at LSB.
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               is_mod;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
`endif

    always_comb begin
        as_b   = (command == CMD_SUB) ? ~in_b : in_b;
        as_sum = {1'b0, in_a} + {1'b0, as_b}
               + {{WIDTH{1'b0}}, (command == CMD_SUB)};
        // Same-sign operands producing a different-sign sum is exactly the
        // case where carry into the MSB differs from carry out of it.
        as_ovf = (in_a[WIDTH-1] == as_b[WIDTH-1])
              && (as_sum[WIDTH-1] != in_a[WIDTH-1]);
        mul_acc_next = mplier[0] ? (acc + mcand) : acc;
    end

`ifdef SEQ_ALU_DIV_EN
    always_comb begin
        div_trial    = {rem, quo[WIDTH-1]};
        div_ge       = (div_trial >= {1'b0, dvsr});
        // When div_ge holds the difference is below dvsr, so WIDTH bits suffice.
        div_rem_next = div_ge ? (div_trial[WIDTH-1:0] - dvsr) : div_trial[WIDTH-1:0];
        div_quo_next = {quo[WIDTH-2:0], div_ge};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            error  <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
`ifdef SEQ_ALU_DIV_EN
            dvsr   <= '0;
            rem    <= '0;
            quo    <= '0;
            is_mod <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_MUL: begin
                    acc    <= mul_acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= mul_acc_next;
                        error  <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                ST_DIV: begin
                    rem <= div_rem_next;
                    quo <= div_quo_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= is_mod ? {{WIDTH{1'b0}}, div_rem_next}
                                         : {{WIDTH{1'b0}}, div_quo_next};
                        error  <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
`endif
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        case (command)
                            CMD_ADD, CMD_SUB: begin
                                result <= {{(WIDTH-1){1'b0}}, as_sum};
                                error  <= as_ovf;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            CMD_MUL: begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, in_a};
                                mplier <= in_b;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= ST_MUL;
                            end
                            CMD_DIV, CMD_MOD: begin
`ifdef SEQ_ALU_DIV_EN
                                if (in_b == '0) begin
                                    // Divide by zero short-circuits the sequencer.
                                    result <= (command == CMD_DIV)
                                            ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                            : {{WIDTH{1'b0}}, in_a};
                                    error  <= 1'b1;
                                    done   <= 1'b1;
                                    state  <= ST_DONE;
                                end else begin
                                    rem    <= '0;
                                    quo    <= in_a;
                                    dvsr   <= in_b;
                                    is_mod <= (command == CMD_MOD);
                                    cnt    <= '0;
                                    busy   <= 1'b1;
                                    state  <= ST_DIV;
                                end
`else
                                result <= '0;
                                error  <= 1'b1;
                                done   <= 1'b1;
                                state  <= ST_DONE;
`endif
                            end
                            default: begin
                                result <= '0;
                                error  <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
